// File: rtl/router_fifo_mem_if.sv
// rtl/router_fifo_mem_if.sv - byte link / flit bundle between the link side and the router input FIFO
interface router_fifo_mem_if #(
  parameter int DATA_W     = 8,
  parameter int FLIT_BYTES = 4
);
  logic                         wr;
  logic                         rd;
  logic [DATA_W-1:0]            data_in;
  logic [DATA_W-1:0]            data_out;
  logic [DATA_W*FLIT_BYTES-1:0] flit;
  logic                         flit_avl;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_threshold;
  logic                         fifo_overflow;
  logic                         fifo_underflow;

  modport master (
    output wr, rd, data_in,
    input  data_out, flit, flit_avl,
    input  fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  wr, rd, data_in,
    output data_out, flit, flit_avl,
    output fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/router_fifo_mem.sv
// rtl/router_fifo_mem.sv - 16x8 router input FIFO with status flags and a 4-byte flit packer
module router_fifo_mem #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int THRESHOLD  = 8,
  parameter int FLIT_BYTES = 4
) (
  input logic               clk,
  input logic               rst_n,
  router_fifo_mem_if.slave  bus
);
  localparam int              FLIT_W    = DATA_W * FLIT_BYTES;
  localparam int              CNT_W     = $clog2(FLIT_BYTES);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] THR_CNT   = (ADDR_W + 1)'(THRESHOLD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FLIT_BYTES - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   count;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] data_out_q;
  logic [FLIT_W-1:0] flit_q;
  logic              flit_avl_q;
  logic              full;
  logic              empty;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] rd_byte;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign we      = bus.wr & ~full;
  assign re      = bus.rd & ~empty;
  assign rd_byte = mem[rptr[ADDR_W-1:0]];

  assign bus.fifo_full      = full;
  assign bus.fifo_empty     = empty;
  assign bus.fifo_threshold = (count >= THR_CNT);
  assign bus.fifo_overflow  = bus.wr & full;
  assign bus.fifo_underflow = bus.rd & empty;
  assign bus.data_out       = data_out_q;
  assign bus.flit           = flit_q;
  assign bus.flit_avl       = flit_avl_q;

  // Storage is deliberately left out of reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr[ADDR_W-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (we) begin
        wptr <= wptr + 1'b1;
      end
      if (re) begin
        rptr <= rptr + 1'b1;
      end
      if (we && !re) begin
        count <= count + 1'b1;
      end else if (re && !we) begin
        count <= count - 1'b1;
      end
    end
  end

  // First byte of a group shifts up into the top of the flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      flit_q     <= '0;
      flit_avl_q <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      flit_avl_q <= re && (byte_cnt == LAST_BYTE);
      if (re) begin
        data_out_q <= rd_byte;
        flit_q     <= {flit_q[FLIT_W-DATA_W-1:0], rd_byte};
        byte_cnt   <= byte_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_router_fifo_mem.sv
// tb/tb_router_fifo_mem.sv - scoreboard bench for router_fifo_mem
module tb_router_fifo_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  router_fifo_mem_if bus ();

  router_fifo_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  sb [$];
  int          count = 0;
  int          nbytes = 0;
  logic [31:0] exp_flit = '0;
  logic [7:0]  last_out = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_empty", bus.fifo_empty, 1'b1);
    check("rst_full", bus.fifo_full, 1'b0);
    check("rst_thr", bus.fifo_threshold, 1'b0);
    check("rst_ovf", bus.fifo_overflow, 1'b0);
    check("rst_udf", bus.fifo_underflow, 1'b0);
    check("rst_dout", bus.data_out, 8'h00);
    check("rst_flit", bus.flit, 32'h0);
    check("rst_avl", bus.flit_avl, 1'b0);
  endtask

  // One clock of stimulus; called 1ns after a rising edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    logic       exp_we;
    logic       exp_re;
    logic [7:0] b;
    bus.wr = w;
    bus.rd = r;
    bus.data_in = d;
    #1;
    check("overflow", bus.fifo_overflow, w && (count == 16));
    check("underflow", bus.fifo_underflow, r && (count == 0));
    exp_we = w && (count < 16);
    exp_re = r && (count > 0);
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    if (exp_re) begin
      b = sb.pop_front();
      last_out = b;
      exp_flit = {exp_flit[23:0], b};
      nbytes++;
    end
    if (exp_we) sb.push_back(d);
    count = count + int'(exp_we) - int'(exp_re);
    check("data_out", bus.data_out, last_out);
    check("flit_avl", bus.flit_avl, exp_re && (nbytes % 4 == 0));
    if (exp_re && (nbytes % 4 == 0)) check("flit", bus.flit, exp_flit);
    check("empty", bus.fifo_empty, count == 0);
    check("full", bus.fifo_full, count == 16);
    check("threshold", bus.fifo_threshold, count >= 8);
  endtask

  initial begin
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.data_in = '0;

    #3 rst_n = 1'b0;
    #1 check_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 20; i++) cycle(1'b1, i > 0, 8'hA0 + 8'(i));
    check("wrap_count", 32'(count), 32'd1);

    #2 rst_n = 1'b0;
    #1 check_reset();
    sb.delete();
    count = 0;
    nbytes = 0;
    exp_flit = '0;
    last_out = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_fifo_mem.md
Name: router_fifo_mem

Overview:
- 16-entry × 8-bit synchronous FIFO for the router input path.
- Standard status flags: full, empty, threshold, overflow, underflow.
- A read-side packer assembles every four consecutive bytes read into a 32-bit flit.
- Sits between the byte-wide link interface and the router's flit-level logic.

Parameters:
- DATA_W, 8, byte width of data_in/data_out.
- DEPTH, 16, number of FIFO entries (power of two).
- ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits wide.
- THRESHOLD, 8, occupancy at or above which fifo_threshold asserts.
- FLIT_BYTES, 4, bytes per flit; flit width = DATA_W*FLIT_BYTES = 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr  input  1  write request; one byte per clock edge while high.
- rd  input  1  read request; one byte per clock edge while high.
- data_in  input  8  write data, sampled on a rising edge with wr=1.
- data_out  output  8  registered read data.
- flit  output  32  registered assembled flit.
- flit_avl  output  1  one-cycle pulse: flit holds a new complete flit.
- fifo_full  output  1  occupancy == DEPTH.
- fifo_empty  output  1  occupancy == 0.
- fifo_threshold  output  1  occupancy >= THRESHOLD.
- fifo_overflow  output  1  write attempted while full.
- fifo_underflow  output  1  read attempted while empty.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - Write pointer, read pointer and occupancy count clear to 0.
  - data_out=0, flit=0, flit_avl=0, byte counter=0.
  - Resulting flags: fifo_empty=1; fifo_full, fifo_threshold, fifo_overflow, fifo_underflow all 0.
  - Memory contents are not cleared (don't-care).
- Write enable: we = wr & ~fifo_full.
  - On rising edge with we: mem[wptr[3:0]] <= data_in, wptr += 1.
- Read enable: re = rd & ~fifo_empty.
  - On rising edge with re: data_out <= mem[rptr[3:0]], rptr += 1.
  - data_out holds its value when re=0.
  - Read latency: data valid after the same edge that accepts the read.
- Pointers are 5 bits and wrap naturally modulo 32; memory is indexed by the low 4 bits.
- Occupancy count: +1 on we only, −1 on re only, unchanged when both or neither.
- Simultaneous wr and rd:
  - Both not-full and not-empty: both occur, count unchanged.
  - Full with wr&rd: read occurs, write is blocked (overflow asserts).
  - Empty with wr&rd: write occurs, read is blocked (underflow asserts; data_out holds).
- Flags are combinational from count, pointers and requests:
  - fifo_full = (count == 16).
  - fifo_empty = (count == 0).
  - fifo_threshold = (count >= 8).
  - fifo_overflow = wr & fifo_full.
  - fifo_underflow = rd & fifo_empty.
- A blocked write discards data_in. A blocked read changes nothing.
- Flit packer:
  - On each re edge, flit <= {flit[23:0], byte_read}, so the first byte of a group lands in flit[31:24].
  - 2-bit byte counter increments on each re edge.
  - When it increments from 3 to 0, flit_avl=1 for exactly the following cycle; otherwise flit_avl=0.
  - flit is stable while flit_avl=1 and holds until the next re.
  - Partial groups persist across idle cycles; only reset clears them.

Test Plan:
- Reset: assert rst_n=0 asynchronously between clock edges -> immediately fifo_empty=1, all other flags 0, data_out=0, flit=0, flit_avl=0.
- Fill: write 0x01..0x10, one pulse per clock.
  - fifo_threshold rises after the 8th write.
  - fifo_full=1 after the 16th write; fifo_empty=0 after the 1st.
- Overflow: 17th write of 0x11 while full -> fifo_overflow=1 during the wr pulse; count stays 16; 0x11 is not stored.
- Drain: 16 single reads.
  - data_out sequence 0x01..0x10.
  - flit_avl pulses after reads 4, 8, 12, 16 with flit = 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10.
  - fifo_threshold falls when count drops to 7; fifo_empty=1 after the 16th read.
- Underflow: 17th read while empty -> fifo_underflow=1 during the rd pulse; data_out stays 0x10; flit_avl stays 0.
- Wrap and concurrency:
  - Write 20 bytes, reading concurrently from the second write onward -> data in order, pointers wrap past entry 15 correctly, count never exceeds 1.
  - Assert reset mid-stream -> FIFO empty and the partial flit is discarded.
